// File: rtl/multdiv_booth_multiplier.sv
// Sequential radix-4 (modified Booth) signed multiplier.
// One start pulse latches both operands; WIDTH/2 iterations later the low
// WIDTH bits of the product and an overflow flag are registered and
// data_resultRDY pulses for one cycle. A start while busy or done restarts.
module multdiv_booth_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int ITERS = WIDTH / 2;
   localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam int AW    = WIDTH + 2;          // accumulator incl. guard bits
   localparam int PW    = AW + WIDTH + 1;     // {acc, multiplier, q-1}

   localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [AW-1:0] ACC_ONE  = AW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     m_q, m_d;
   logic [PW-1:0]     p_q, p_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic              exc_q, exc_d;

   logic [AW-1:0]     addend;
   logic [AW-1:0]     acc_sum;
   logic [PW-1:0]     p_shift;
   logic [WIDTH:0]    prod_hi;

   // Booth recoding of the current triplet, accumulate, then arithmetic shift by 2
   always_comb begin
      addend = '0;
      case (p_q[2:0])
         3'b001, 3'b010: addend = m_q;
         3'b011:         addend = {m_q[AW-2:0], 1'b0};
         3'b100:         addend = ~{m_q[AW-2:0], 1'b0} + ACC_ONE;
         3'b101, 3'b110: addend = ~m_q + ACC_ONE;
         default:        addend = '0;
      endcase
      acc_sum = p_q[PW-1 -: AW] + addend;
      p_shift = PW'($signed({acc_sum, p_q[WIDTH:0]}) >>> 2);
      // Product bits 2*WIDTH-1 .. WIDTH-1 live at p_shift[2*WIDTH:WIDTH]
      prod_hi = p_shift[2*WIDTH:WIDTH];
   end

   // Next-state and datapath control
   always_comb begin
      state_d  = state_q;
      m_d      = m_q;
      p_d      = p_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      exc_d    = exc_q;
      if (ctrl_MULT) begin
         // A start in any state discards whatever was in flight
         m_d     = {{2{data_operandA[WIDTH-1]}}, data_operandA};
         p_d     = {{AW{1'b0}}, data_operandB, 1'b0};
         cnt_d   = '0;
         state_d = BUSY;
      end else begin
         case (state_q)
            BUSY: begin
               p_d   = p_shift;
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  result_d = p_shift[WIDTH:1];
                  exc_d    = !((&prod_hi) || (~|prod_hi));
                  state_d  = DONE;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers; reset aborts any operation immediately
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         m_q      <= '0;
         p_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         exc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         p_q      <= p_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         exc_q    <= exc_d;
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = (state_q == DONE);
   assign busy           = (state_q == BUSY);

endmodule
